sha256_block_engine: RTL and testbench

- Sequential, iterative SHA-256 compression engine and successor to the fully combinational hash datapath.
- Accepts pre-padded 512-bit message blocks over a valid/ready stream and chains any number of blocks per message.
- Runs ROUNDS_PER_CYCLE rounds per clock and can optionally hash the digest a second time (SHA-256d, as used for Bitcoin headers).
- Sits between the bit-padding stage and the nonce/target comparator in the miner.

---
 rtl/sha256_block_engine.sv | 151 +++++++++++++++
 tb/tb_sha256_block_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sha256_block_engine.sv
// sha256_block_engine: iterative SHA-256 compression with block chaining and optional SHA-256d
package sha256_constants;
    localparam logic [31:0] h_constants [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] k_constants [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
endpackage

module sha256_block_engine
    import sha256_constants::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit DOUBLE_HASH = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_last,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] dig_data,
    output logic         busy
);
    localparam int N = 64 / ROUNDS_PER_CYCLE;

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
        $fatal(1, "sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    typedef enum logic [2:0] {IDLE, ROUND, UPDATE, WAIT_BLK, DONE} state_t;

    state_t      st, st_nxt;
    logic [31:0] win [16];
    logic [31:0] wn [16];
    logic [31:0] v [8];
    logic [31:0] vn [8];
    logic [31:0] hh [8];
    logic [31:0] hn [8];
    logic [31:0] t1, t2, nw;
    logic [5:0]  cnt, ki;
    logic        last, pass;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign blk_ready = (st == IDLE) || (st == WAIT_BLK);
    assign dig_valid = (st == DONE);
    assign busy      = (st != IDLE);

    always_comb begin
        st_nxt = st;
        unique case (st)
            IDLE, WAIT_BLK: st_nxt = blk_valid ? ROUND : st;
            ROUND:          st_nxt = (cnt == 6'(N - 1)) ? UPDATE : ROUND;
            UPDATE:         st_nxt = !last ? WAIT_BLK : (!DOUBLE_HASH || pass) ? DONE : ROUND;
            DONE:           st_nxt = dig_ready ? IDLE : DONE;
            default:        st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nxt;
    end

    // Window slot 0 always holds W[t]; each round appends W[t+16] at slot 15
    always_comb begin
        wn = win;
        vn = v;
        t1 = '0;
        t2 = '0;
        nw = '0;
        ki = '0;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            ki = 6'(int'(cnt) * ROUNDS_PER_CYCLE + i);
            t1 = vn[7] + (rotr(vn[4], 6) ^ rotr(vn[4], 11) ^ rotr(vn[4], 25))
               + ((vn[4] & vn[5]) ^ (~vn[4] & vn[6])) + k_constants[ki] + wn[0];
            t2 = (rotr(vn[0], 2) ^ rotr(vn[0], 13) ^ rotr(vn[0], 22))
               + ((vn[0] & vn[1]) ^ (vn[0] & vn[2]) ^ (vn[1] & vn[2]));
            nw = (rotr(wn[14], 17) ^ rotr(wn[14], 19) ^ (wn[14] >> 10)) + wn[9]
               + (rotr(wn[1], 7) ^ rotr(wn[1], 18) ^ (wn[1] >> 3)) + wn[0];
            for (int j = 7; j > 0; j--) vn[j] = vn[j-1];
            vn[4] = vn[4] + t1;
            vn[0] = t1 + t2;
            for (int j = 0; j < 15; j++) wn[j] = wn[j+1];
            wn[15] = nw;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) hn[i] = hh[i] + v[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            last     <= 1'b0;
            pass     <= 1'b0;
            dig_data <= '0;
            hh       <= h_constants;
            v        <= h_constants;
            win      <= '{default: '0};
        end else begin
            unique case (st)
                IDLE, WAIT_BLK: if (blk_valid) begin
                    for (int j = 0; j < 16; j++) win[j] <= blk_data[511 - 32*j -: 32];
                    v    <= hh;  // hh is the IV whenever the engine sits in IDLE
                    last <= blk_last;
                    cnt  <= '0;
                end
                ROUND: begin
                    win <= wn;
                    v   <= vn;
                    cnt <= cnt + 6'd1;
                end
                UPDATE: if (!last || !DOUBLE_HASH || pass) begin
                    hh <= hn;
                    if (last) for (int i = 0; i < 8; i++) dig_data[255 - 32*i -: 32] <= hn[i];
                end else begin
                    // Second pass: the 256-bit digest padded as a one-block message
                    pass <= 1'b1;
                    hh   <= h_constants;
                    v    <= h_constants;
                    cnt  <= '0;
                    for (int j = 0; j < 8; j++) win[j] <= hn[j];
                    win[8] <= 32'h80000000;
                    for (int j = 9; j < 15; j++) win[j] <= '0;
                    win[15] <= 32'h00000100;
                end
                DONE: if (dig_ready) begin
                    hh   <= h_constants;
                    pass <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_block_engine.sv
// tb_sha256_block_engine: directed checks of single/multi-block, SHA-256d, back-pressure and reset across R
module tb_sha256_block_engine;
    localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2    = {480'h0, 32'h000001c0};
    localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_2B  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_DBL = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_last = 1'b0;
    logic         dig_ready = 1'b1;
    logic [511:0] blk_data = '0;
    logic [4:0]   bv = '0;
    logic [4:0]   br, dv, bz;
    logic [255:0] dd [5];
    logic [255:0] sb [$];
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    // Instances 0..3 run R=1,2,4,8 single hash; instance 4 runs R=2 with SHA-256d
    for (genvar g = 0; g < 5; g++) begin : g_dut
        sha256_block_engine #(
            .ROUNDS_PER_CYCLE(g == 4 ? 2 : 1 << g),
            .DOUBLE_HASH(g == 4)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .blk_valid(bv[g]),
            .blk_ready(br[g]),
            .blk_data(blk_data),
            .blk_last(blk_last),
            .dig_valid(dv[g]),
            .dig_ready(dig_ready),
            .dig_data(dd[g]),
            .busy(bz[g])
        );
    end

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(int u, logic [511:0] d, logic l, logic [255:0] exp);
        int n = 0;
        blk_data = d;
        blk_last = l;
        bv[u] = 1'b1;
        while (!br[u] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 256'(n < 100), 256'(1));
        @(posedge clk);
        if (l) sb.push_back(exp);
        @(negedge clk);
        bv[u] = 1'b0;
    endtask

    task automatic wait_dig(int u, int lat, string tag);
        int c = 0;
        while (!dv[u] && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_latency"}, 256'(c), 256'(lat));
    endtask

    task automatic take(int u, string tag);
        logic [255:0] e;
        if (sb.size() != 0) e = sb.pop_front();
        else e = 'x;
        chk({tag, "_valid"}, 256'(dv[u]), 256'(1));
        chk({tag, "_digest"}, dd[u], e);
        dig_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy_after"}, 256'(bz[u]), 256'(0));
        chk({tag, "_ready_after"}, 256'(br[u]), 256'(1));
        chk({tag, "_valid_after"}, 256'(dv[u]), 256'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int u = 0; u < 5; u++) begin
            chk("rst_ready", 256'(br[u]), 256'(1));
            chk("rst_valid", 256'(dv[u]), 256'(0));
            chk("rst_busy", 256'(bz[u]), 256'(0));
            chk("rst_data", dd[u], 256'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        send(0, ABC, 1'b1, D_ABC);
        wait_dig(0, 65, "abc_r1");
        take(0, "abc_r1");
        // Two-block message with a 5-cycle upstream gap
        send(2, B1, 1'b0, '0);
        begin
            int c = 0;
            while (!br[2] && c < 100) begin
                @(negedge clk);
                c++;
            end
            chk("two_blk_wait_latency", 256'(c), 256'(17));
        end
        chk("two_blk_wait_busy", 256'(bz[2]), 256'(1));
        repeat (5) @(negedge clk);
        chk("two_blk_gap_ready", 256'(br[2]), 256'(1));
        chk("two_blk_gap_valid", 256'(dv[2]), 256'(0));
        send(2, B2, 1'b1, D_2B);
        wait_dig(2, 17, "two_blk");
        take(2, "two_blk");
        send(4, EMPTY, 1'b1, D_DBL);
        wait_dig(4, 66, "dbl");
        take(4, "dbl");
        // Digest held under back-pressure while a new block waits
        dig_ready = 1'b0;
        send(1, EMPTY, 1'b1, D_EMP);
        wait_dig(1, 33, "hold");
        blk_data = ABC;
        blk_last = 1'b1;
        bv[1] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("hold_data", dd[1], D_EMP);
            chk("hold_blk_ready", 256'(br[1]), 256'(0));
        end
        take(1, "hold");
        send(1, ABC, 1'b1, D_ABC);
        wait_dig(1, 33, "after_hold");
        take(1, "after_hold");
        // Asynchronous reset in the middle of round processing
        send(0, ABC, 1'b1, D_ABC);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 256'(br[0]), 256'(1));
        chk("midrst_valid", 256'(dv[0]), 256'(0));
        chk("midrst_busy", 256'(bz[0]), 256'(0));
        chk("midrst_data", dd[0], 256'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 256'(dv[0]), 256'(0));
        send(0, ABC, 1'b1, D_ABC);
        wait_dig(0, 65, "post_rst");
        take(0, "post_rst");
        for (int u = 0; u < 4; u++) begin
            send(u, ABC, 1'b1, D_ABC);
            wait_dig(u, 64 / (1 << u) + 1, "sweep");
            take(u, "sweep");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
